ct_f_spsram_512x7_ctrl: RTL and testbench
=========================================

Name: ct_f_spsram_512x7_ctrl

Overview:
Initiator-side controller for the 512x7 single-port SRAM macro interface (A/CEN/GWEN/WEN/D/Q, all enables active-low). After reset it sweeps every entry to INIT_VAL. It then serves a valid/ready read/write request port from the owning logic, generating macro strobes and returning read data through a fixed-latency response pipeline. It sits between cache/predictor control logic and the SRAM macro, one instance per macro.

Parameters:
ADDR_WIDTH, 9, macro address width
DATA_WIDTH, 7, macro data width
DEPTH, 512, number of entries swept during init (must equal 2^ADDR_WIDTH)
INIT_VAL, 7'b0, value written to every entry during init

Ports:
CLK  input  1  clock; same clock drives the macro
RST  input  1  reset, synchronous, active-high
init_req  input  1  pulse: restart full init sweep
init_done  output  1  high once a sweep has completed and no sweep is running
req_vld  input  1  client request valid
req_rdy  output  1  controller accepts request this cycle
req_wr  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
req_bwen  input  DATA_WIDTH  per-bit write enable, active-low (0=write bit)
rsp_vld  output  1  read data valid (one-cycle pulse, no backpressure)
rsp_rdata  output  DATA_WIDTH  read data
sram_A  output  ADDR_WIDTH  macro address
sram_CEN  output  1  macro chip enable, active-low
sram_GWEN  output  1  macro global write enable, active-low
sram_WEN  output  DATA_WIDTH  macro bit write enables, active-low
sram_D  output  DATA_WIDTH  macro write data
sram_Q  input  DATA_WIDTH  macro read data, valid the cycle after a read access

Behaviour:
- Reset is synchronous and active-high; one clock (CLK). While RST=1: state=INIT, init_cnt=0, init_done=0, req_rdy=0, rsp_vld=0, rsp_rdata=0, rd_p1=0, sram_CEN=1, sram_GWEN=1, sram_WEN=all-1.
- States: INIT, RUN.
- INIT: each cycle drive CEN=0, GWEN=0, WEN=all-0, A=init_cnt, D=INIT_VAL; increment init_cnt.
  - When init_cnt==DEPTH-1 is written, go to RUN and clear init_cnt.
  - req_rdy=0 throughout. A sweep takes exactly DEPTH cycles. With cycle 0 as the first cycle with RST=0, addresses 0..511 are written in cycles 0..511; RUN, init_done=1 and req_rdy=1 from cycle 512.
- RUN:
  - req_rdy = !init_req. A handshake occurs when req_vld && req_rdy.
  - On handshake: CEN=0, A=req_addr.
    - Write: GWEN=0, WEN=req_bwen, D=req_wdata.
    - Read: GWEN=1, WEN=all-1.
  - No handshake: CEN=1, GWEN=1, WEN=all-1; A and D hold their previous values. No spurious access.
  - Write accepted with req_bwen all-1: CEN=0, GWEN=0, no bits modified. This is legal.
- init_req:
  - In RUN: next cycle enters INIT with init_cnt=0, and init_done drops to 0 that next cycle. A request presented in the init_req cycle is not accepted.
  - In INIT: restarts the sweep at init_cnt=0 next cycle.
  - Takes priority over sweep completion in the same cycle.
- Read pipeline:
  - Accepted read in cycle T sets rd_p1 in T+1.
  - In T+1, sram_Q is captured into rsp_rdata. rsp_vld=1 in T+2 only.
  - Read latency is 2 cycles, fully pipelined: back-to-back reads give back-to-back responses.
  - Reads in flight when init_req arrives still complete and respond.
- Ordering: a write in T followed by a read of the same address in T+1 returns the new data. Bits with WEN=1 keep their old value.
- No internal buffering. The client must hold req_* stable while req_vld && !req_rdy.
- Outputs sram_* are combinational from state/requests plus the registered init_cnt. rsp_* and init_done are registered.

Test Plan:
- Init sweep: deassert RST, hold req_vld=1 -> exactly 512 writes of 7'h00 at A=0..511 on consecutive cycles; req_rdy=0 until cycle 512; init_done=1 at cycle 512.
- Write/read: write addr 9'h1A5 data 7'h5A with bwen 7'h00; read 9'h1A5 next cycle -> rsp_vld pulses 2 cycles after read acceptance, rsp_rdata=7'h5A.
- Partial write: after the above, write 9'h1A5 data 7'h7F with bwen 7'b1110000, then read -> rsp_rdata=7'h5F.
- Back-to-back reads of 0x000, 0x1FF, 0x100 after writing 7'h11, 7'h22, 7'h33 -> three consecutive rsp_vld cycles with data 7'h11, 7'h22, 7'h33.
- init_req asserted the cycle after a read to 0x1FF is accepted -> the read response still arrives with 7'h22; req_rdy=0 for 512 cycles; afterwards a read of 0x1FF returns 7'h00.
- Reset mid-sweep at init_cnt=200 -> next cycle sram_CEN=1 and init_done=0; after RST release the sweep restarts at A=0 and takes 512 cycles. Idle RUN with req_vld=0 -> sram_CEN stays 1 every cycle.

Source files
------------

// File: rtl/ct_f_spsram_512x7_ctrl.sv
// Initiator-side controller for a 512x7 single-port SRAM macro: post-reset init sweep,
// valid/ready client port, and a two-cycle read response pipeline.
module ct_f_spsram_512x7_ctrl #(
  parameter int unsigned             ADDR_WIDTH = 9,
  parameter int unsigned             DATA_WIDTH = 7,
  parameter int unsigned             DEPTH      = 512,
  parameter logic [DATA_WIDTH-1:0]   INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwen,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic                  sram_CEN,
  output logic                  sram_GWEN,
  output logic [DATA_WIDTH-1:0] sram_WEN,
  output logic [DATA_WIDTH-1:0] sram_D,
  input  logic [DATA_WIDTH-1:0] sram_Q
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q;
  logic                  rd_p1_q;
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  hs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_p1_q     <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      a_q         <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == ST_RUN);
      rd_p1_q     <= hs && !req_wr;
      rsp_vld_q   <= rd_p1_q;
      if (rd_p1_q) rsp_rdata_q <= sram_Q;
      // Macro pins A/D keep their last driven value on idle cycles.
      a_q         <= sram_A;
      d_q         <= sram_D;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_req) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    req_rdy   = (state_q == ST_RUN) && !init_req && !RST;
    hs        = req_vld && req_rdy;
    sram_CEN  = 1'b1;
    sram_GWEN = 1'b1;
    sram_WEN  = '1;
    sram_A    = a_q;
    sram_D    = d_q;
    if (!RST && state_q == ST_INIT) begin
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_WEN  = '0;
      sram_A    = init_cnt_q;
      sram_D    = INIT_VAL;
    end else if (hs) begin
      sram_CEN = 1'b0;
      sram_A   = req_addr;
      if (req_wr) begin
        sram_GWEN = 1'b0;
        sram_WEN  = req_bwen;
        sram_D    = req_wdata;
      end
    end
  end

  assign init_done = init_done_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ct_f_spsram_512x7_ctrl.sv
// Directed self-checking bench for ct_f_spsram_512x7_ctrl with a behavioural 512x7 macro.
module tb_ct_f_spsram_512x7_ctrl;

  logic       clk = 1'b0;
  logic       RST, init_req, init_done;
  logic       req_vld, req_rdy, req_wr;
  logic [8:0] req_addr;
  logic [6:0] req_wdata, req_bwen;
  logic       rsp_vld;
  logic [6:0] rsp_rdata;
  logic [8:0] sram_A;
  logic       sram_CEN, sram_GWEN;
  logic [6:0] sram_WEN, sram_D, sram_Q;

  int tests = 0;
  int fails = 0;

  logic [6:0] mem [512];

  always #5 clk = ~clk;

  ct_f_spsram_512x7_ctrl #(
    .ADDR_WIDTH(9),
    .DATA_WIDTH(7),
    .DEPTH     (512),
    .INIT_VAL  (7'h00)
  ) dut (
    .CLK      (clk),
    .RST      (RST),
    .init_req (init_req),
    .init_done(init_done),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_bwen (req_bwen),
    .rsp_vld  (rsp_vld),
    .rsp_rdata(rsp_rdata),
    .sram_A   (sram_A),
    .sram_CEN (sram_CEN),
    .sram_GWEN(sram_GWEN),
    .sram_WEN (sram_WEN),
    .sram_D   (sram_D),
    .sram_Q   (sram_Q)
  );

  // Macro: bit-masked write, registered read data.
  always @(posedge clk) begin
    if (!sram_CEN) begin
      if (!sram_GWEN) mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
      else            sram_Q <= mem[sram_A];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [8:0] a, input logic [6:0] d, input logic [6:0] bw);
    tick();
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_bwen = bw;
    #1;
  endtask

  task automatic do_rd(input logic [8:0] a);
    tick();
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
    #1;
  endtask

  task automatic idle();
    tick();
    req_vld = 1'b0;
    #1;
  endtask

  // Caller is already at the check point of sweep cycle 0.
  task automatic sweep(input string tag);
    for (int i = 0; i < 512; i++) begin
      if (i != 0) begin
        tick();
        #1;
      end
      chk(tag, 32'({sram_CEN, sram_GWEN, sram_WEN, sram_A, sram_D, req_rdy, init_done}),
               32'({1'b0, 1'b0, 7'h00, 9'(i), 7'h00, 1'b0, 1'b0}));
    end
  endtask

  initial begin
    RST = 1'b1; init_req = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; req_bwen = '1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cen",   32'(sram_CEN),  32'h1);
    chk("rst_gwen",  32'(sram_GWEN), 32'h1);
    chk("rst_wen",   32'(sram_WEN),  32'h7F);
    chk("rst_rdy",   32'(req_rdy),   32'h0);
    chk("rst_done",  32'(init_done), 32'h0);
    chk("rst_rsp",   32'(rsp_vld),   32'h0);
    chk("rst_rdata", 32'(rsp_rdata), 32'h0);

    tick();
    RST = 1'b0; req_vld = 1'b1; req_wr = 1'b0; req_addr = '0;
    #1;
    sweep("init_sweep");

    do_wr(9'h1A5, 7'h5A, 7'h00);
    chk("run_done",  32'(init_done), 32'h1);
    chk("run_rdy",   32'(req_rdy),   32'h1);
    chk("wr_pins",   32'({sram_CEN, sram_GWEN, sram_WEN, sram_A, sram_D}),
                     32'({1'b0, 1'b0, 7'h00, 9'h1A5, 7'h5A}));
    do_rd(9'h1A5);
    chk("rd_pins",   32'({sram_CEN, sram_GWEN, sram_WEN, sram_A}),
                     32'({1'b0, 1'b1, 7'h7F, 9'h1A5}));
    idle();
    chk("idle_pins", 32'({sram_CEN, sram_GWEN, sram_WEN, sram_A, sram_D}),
                     32'({1'b1, 1'b1, 7'h7F, 9'h1A5, 7'h5A}));
    chk("rsp_lat1",  32'(rsp_vld), 32'h0);
    do_wr(9'h1A5, 7'h7F, 7'b1110000);
    chk("rsp_vld_a", 32'(rsp_vld),   32'h1);
    chk("rsp_dat_a", 32'(rsp_rdata), 32'h5A);
    do_rd(9'h1A5);
    chk("rsp_pulse", 32'(rsp_vld), 32'h0);
    idle();
    idle();
    chk("rsp_vld_p", 32'(rsp_vld),   32'h1);
    chk("rsp_dat_p", 32'(rsp_rdata), 32'h5F);

    do_wr(9'h000, 7'h11, 7'h00);
    do_wr(9'h1FF, 7'h22, 7'h00);
    do_wr(9'h100, 7'h33, 7'h00);
    do_rd(9'h000);
    do_rd(9'h1FF);
    do_rd(9'h100);
    chk("b2b_vld0", 32'(rsp_vld),   32'h1);
    chk("b2b_dat0", 32'(rsp_rdata), 32'h11);
    idle();
    chk("b2b_vld1", 32'(rsp_vld),   32'h1);
    chk("b2b_dat1", 32'(rsp_rdata), 32'h22);
    idle();
    chk("b2b_vld2", 32'(rsp_vld),   32'h1);
    chk("b2b_dat2", 32'(rsp_rdata), 32'h33);
    idle();
    chk("b2b_end",  32'(rsp_vld),   32'h0);

    do_rd(9'h1FF);
    tick();
    init_req = 1'b1; req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h000;
    #1;
    chk("ireq_rdy",  32'(req_rdy),   32'h0);
    chk("ireq_cen",  32'(sram_CEN),  32'h1);
    chk("ireq_done", 32'(init_done), 32'h1);
    tick();
    init_req = 1'b0; req_vld = 1'b0;
    #1;
    chk("inflt_vld", 32'(rsp_vld),   32'h1);
    chk("inflt_dat", 32'(rsp_rdata), 32'h22);
    sweep("reinit_sweep");
    do_rd(9'h1FF);
    chk("reinit_done", 32'(init_done), 32'h1);
    chk("reinit_rdy",  32'(req_rdy),   32'h1);
    idle();
    idle();
    chk("reinit_vld", 32'(rsp_vld),   32'h1);
    chk("reinit_dat", 32'(rsp_rdata), 32'h00);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("idle_cen", 32'(sram_CEN), 32'h1);
    end

    tick();
    init_req = 1'b1;
    #1;
    tick();
    init_req = 1'b0;
    #1;
    repeat (200) tick();
    #1;
    chk("mid_a200", 32'({sram_CEN, sram_A}), 32'({1'b0, 9'd200}));
    RST = 1'b1;
    #1;
    tick();
    #1;
    chk("mid_rst_cen",  32'(sram_CEN),  32'h1);
    chk("mid_rst_done", 32'(init_done), 32'h0);
    chk("mid_rst_rdy",  32'(req_rdy),   32'h0);
    tick();
    RST = 1'b0;
    #1;
    sweep("post_rst_sweep");
    tick();
    #1;
    chk("post_done", 32'(init_done), 32'h1);
    chk("post_rdy",  32'(req_rdy),   32'h1);
    for (int k = 0; k < 4; k++) begin
      chk("post_idle_cen", 32'(sram_CEN), 32'h1);
      tick();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
